polydiv_lead_coef: RTL and testbench

POLYDIV_LEAD_COEF -- requirements
Module: polydiv_lead_coef

---
 rtl/polydiv_pkg.sv | 30 +++
 rtl/modmul_4591.sv | 20 ++
 rtl/polydiv_lead_coef.sv | 155 +++++++++++++++
 tb/tb_polydiv_lead_coef.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/polydiv_pkg.sv
// Shared constants and state encoding for the GF(4591) leading-coefficient divider.
package polydiv_pkg;

    localparam int unsigned COEF_W = 13;
    localparam int unsigned IDX_W  = 4;

    localparam logic [COEF_W-1:0] Q       = 13'd4591;
    localparam logic [COEF_W-1:0] EXP_QM2 = 13'd4589;
    localparam logic [IDX_W-1:0]  IDX_TOP = 4'd11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQR  = 3'd1,
        MUL  = 3'd2,
        FIN  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Inputs are below 2*Q, so one conditional subtraction fully reduces them.
    function automatic logic [COEF_W-1:0] reduce_once(input logic [COEF_W-1:0] x);
        logic [COEF_W-1:0] y;
        if (x >= Q) begin
            y = x - Q;
        end else begin
            y = x;
        end
        return y;
    endfunction

endpackage

// File: rtl/modmul_4591.sv
// Combinational multiply of two residues mod 4591 with a full-width product.
module modmul_4591
    import polydiv_pkg::*;
(
    input  logic [COEF_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    output logic [COEF_W-1:0] p
);

    logic [2*COEF_W-1:0] prod_s;
    logic [2*COEF_W-1:0] rem_s;

    // Full 26-bit product, reduced by the constant modulus.
    always_comb begin
        prod_s = a * b;
        rem_s  = prod_s % {13'd0, Q};
        p      = rem_s[COEF_W-1:0];
    end

endmodule

// File: rtl/polydiv_lead_coef.sv
// Quotient coefficient lead_r / lead_d mod 4591 via Fermat inversion (square-and-multiply).
// Optional zero-divisor short-cut enabled by defining POLYDIV_LEAD_ZERO_CHECK_EN.
module polydiv_lead_coef
    import polydiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [COEF_W-1:0] lead_r,
    input  logic [COEF_W-1:0] lead_d,
    output logic              busy,
    output logic              done,
    output logic [COEF_W-1:0] coef,
    output logic              err
);

    state_t            state_r, state_nx_s;
    logic [COEF_W-1:0] acc_r, acc_nx_s;
    logic [IDX_W-1:0]  idx_r, idx_nx_s;
    logic [COEF_W-1:0] opd_r, opr_r;
    logic [COEF_W-1:0] coef_r, coef_nx_s;
    logic              err_r, err_nx_s;
    logic              busy_r, done_r;
    logic              capture_s;
    logic [COEF_W-1:0] dred_s, rred_s;
    logic [COEF_W-1:0] mul_a_s, mul_b_s, mul_p_s;
    logic [15:0]       exp_ext_s;
    logic              exp_bit_s;

    assign dred_s    = reduce_once(lead_d);
    assign rred_s    = reduce_once(lead_r);
    assign exp_ext_s = {3'd0, EXP_QM2};
    assign exp_bit_s = exp_ext_s[idx_r];

    // Single multiplier shared by the square, multiply and final steps.
    modmul_4591 u_modmul (
        .a (mul_a_s),
        .b (mul_b_s),
        .p (mul_p_s)
    );

    // Next-state, operand selection and result update.
    always_comb begin
        state_nx_s = state_r;
        acc_nx_s   = acc_r;
        idx_nx_s   = idx_r;
        coef_nx_s  = coef_r;
        err_nx_s   = err_r;
        capture_s  = 1'b0;
        mul_a_s    = 13'd0;
        mul_b_s    = 13'd0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    capture_s = 1'b1;
`ifdef POLYDIV_LEAD_ZERO_CHECK_EN
                    if (dred_s == 13'd0) begin
                        state_nx_s = DONE;
                        coef_nx_s  = 13'd0;
                        err_nx_s   = 1'b1;
                    end else begin
                        state_nx_s = SQR;
                        acc_nx_s   = dred_s;
                        idx_nx_s   = IDX_TOP;
                    end
`else
                    state_nx_s = SQR;
                    acc_nx_s   = dred_s;
                    idx_nx_s   = IDX_TOP;
`endif
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SQR: begin
                mul_a_s  = acc_r;
                mul_b_s  = acc_r;
                acc_nx_s = mul_p_s;
                // The index is consumed by MUL when the exponent bit is set.
                if (exp_bit_s) begin
                    state_nx_s = MUL;
                end else if (idx_r == 4'd0) begin
                    state_nx_s = FIN;
                end else begin
                    idx_nx_s   = idx_r - 4'd1;
                    state_nx_s = SQR;
                end
            end
            MUL: begin
                mul_a_s  = acc_r;
                mul_b_s  = opd_r;
                acc_nx_s = mul_p_s;
                if (idx_r == 4'd0) begin
                    state_nx_s = FIN;
                end else begin
                    idx_nx_s   = idx_r - 4'd1;
                    state_nx_s = SQR;
                end
            end
            FIN: begin
                mul_a_s    = acc_r;
                mul_b_s    = opr_r;
                coef_nx_s  = mul_p_s;
                err_nx_s   = 1'b0;
                state_nx_s = DONE;
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            acc_r   <= 13'd0;
            idx_r   <= 4'd0;
            opd_r   <= 13'd0;
            opr_r   <= 13'd0;
            coef_r  <= 13'd0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            acc_r   <= acc_nx_s;
            idx_r   <= idx_nx_s;
            coef_r  <= coef_nx_s;
            err_r   <= err_nx_s;
            busy_r  <= (state_nx_s == SQR) || (state_nx_s == MUL) || (state_nx_s == FIN);
            done_r  <= (state_nx_s == DONE);
            if (capture_s) begin
                opd_r <= dred_s;
                opr_r <= rred_s;
            end else begin
                opd_r <= opd_r;
                opr_r <= opr_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign coef = coef_r;
`ifdef POLYDIV_LEAD_ZERO_CHECK_EN
    assign err  = err_r;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_polydiv_lead_coef.sv
// Randomized self-checking bench for polydiv_lead_coef against a modular-inverse table model.
module tb_polydiv_lead_coef;

    localparam int QI = 4591;
`ifdef POLYDIV_LEAD_ZERO_CHECK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [12:0] lead_r = 13'd0;
    logic [12:0] lead_d = 13'd0;
    logic        busy;
    logic        done;
    logic [12:0] coef;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int inv_tab [QI];

    polydiv_lead_coef dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .lead_r (lead_r),
        .lead_d (lead_d),
        .busy   (busy),
        .done   (done),
        .coef   (coef),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_coef(input int r, input int d);
        int rr, dd;
        rr = r % QI;
        dd = d % QI;
        if (dd == 0) return 0;
        return (rr * inv_tab[dd]) % QI;
    endfunction

    // One transaction; poke re-asserts start with other operands 5 cycles in.
    task automatic run_op(input int r, input int d, input string tag, input bit poke);
        int cyc, busy_cnt, dd, rr, exp_lat;
        bit got, zero_path;
        rr = r % QI;
        dd = d % QI;
        zero_path = ZCHK && (dd == 0);
        exp_lat = zero_path ? 0 : 20;
        @(negedge clk);
        lead_r = 13'(r);
        lead_d = 13'(d);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        lead_r = 13'($urandom);
        lead_d = 13'($urandom);
        cyc = 0;
        busy_cnt = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (poke && cyc == 5) begin
                    start  = 1'b1;
                    lead_r = 13'd1;
                    lead_d = 13'd1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start = 1'b0;
        check_eq({tag, "/done_seen"}, int'(got), 1);
        check_eq({tag, "/latency"}, cyc, exp_lat);
        check_eq({tag, "/busy_cycles"}, busy_cnt, zero_path ? 0 : 20);
        check_eq({tag, "/coef"}, int'(coef), ref_coef(r, d));
        check_eq({tag, "/err"}, int'(err), int'(zero_path));
        if (dd != 0) begin
            check_eq({tag, "/identity"}, (int'(coef) * dd + QI - rr) % QI, 0);
        end
        @(posedge clk);
        #1;
        check_eq({tag, "/done_pulse"}, int'(done), 0);
        check_eq({tag, "/idle_busy"}, int'(busy), 0);
    endtask

    initial begin
        int r, d, sel, cyc;
        bit seen;

        inv_tab[0] = 0;
        inv_tab[1] = 1;
        for (int a = 2; a < QI; a++) begin
            inv_tab[a] = (QI - ((QI / a) * inv_tab[QI % a]) % QI) % QI;
        end

        #1;
        check_eq("reset/busy", int'(busy), 0);
        check_eq("reset/done", int'(done), 0);
        check_eq("reset/coef", int'(coef), 0);
        check_eq("reset/err", int'(err), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_op(1, 1, "r1_d1", 1'b0);
        run_op(3, 2, "r3_d2", 1'b0);
        run_op(5, 4590, "r5_dqm1", 1'b0);
        run_op(7, 4592, "r7_d4592", 1'b0);
        run_op(8191, 1, "rmax_d1", 1'b0);
        run_op(9, 4591, "r9_dq", 1'b0);
        run_op(11, 0, "r11_d0", 1'b0);
        run_op(3, 2, "ignored_start", 1'b1);

        // Start held high through done relaunches after returning to IDLE.
        @(negedge clk);
        lead_r = 13'd3;
        lead_d = 13'd2;
        start  = 1'b1;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("held/first_done", int'(done), 1);
        @(posedge clk);
        #1;
        check_eq("held/idle_gap", int'(busy), 0);
        @(posedge clk);
        #1;
        check_eq("held/relaunch", int'(busy), 1);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("held/second_coef", int'(coef), 2297);
        @(posedge clk);
        #1;

        // Reset in the middle of a computation aborts it silently.
        @(negedge clk);
        lead_r = 13'd1;
        lead_d = 13'd1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort/busy", int'(busy), 0);
        check_eq("abort/done", int'(done), 0);
        check_eq("abort/coef", int'(coef), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check_eq("abort/no_done", int'(seen), 0);
        run_op(3, 2, "after_reset", 1'b0);

        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 15);
            r = $urandom_range(0, 8191);
            if (sel == 0) begin
                d = 0;
            end else if (sel == 1) begin
                d = QI;
            end else begin
                d = $urandom_range(0, 8191);
            end
            run_op(r, d, "rand", 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
